// File: rtl/inbuf_arbiter.sv
// rtl/inbuf_arbiter.sv - single-port BRAM arbiter and circular FIFO controller for the RGB888 input frame memory (option macro INBUF_ARB_RR_EN)
module inbuf_arbiter #(
    parameter int DATA_W = 24,
    parameter int ADDR_W = 17,
    parameter int DEPTH  = 130560
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              flush,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_sof,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sof,
    output logic              bram_ena,
    output logic              bram_wea,
    output logic [ADDR_W-1:0] bram_addra,
    output logic [DATA_W-1:0] bram_dina,
    input  logic [DATA_W-1:0] bram_douta,
    output logic [ADDR_W-1:0] level,
    output logic              sof_err
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] FULL = ADDR_W'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] level_q;
    logic [DATA_W-1:0] fifo_data [2];
    logic [1:0]        fifo_sof;
    logic              fifo_rd_idx;
    logic              fifo_wr_idx;
    logic [1:0]        fifo_count;
    logic              inflight;
    logic              inflight_sof;
    logic              clear;
    logic              wreq;
    logic              rreq;
    logic              wgrant;
    logic              rgrant;
    logic              push;
    logic              pop;
`ifdef INBUF_ARB_RR_EN
    logic              rr_last;  // 1 = writer won the last contested cycle
`endif

    // Request generation and single-access grant; clears block all grants
    always_comb begin
        clear  = rsta | flush;
        wreq   = s_valid && (level_q < FULL);
        rreq   = (level_q != '0) && (({1'b0, fifo_count} + {2'b00, inflight}) < 3'd2);
        wgrant = 1'b0;
        rgrant = 1'b0;
        if (!clear) begin
`ifdef INBUF_ARB_RR_EN
            if (wreq && rreq) begin
                wgrant = !rr_last;
                rgrant = rr_last;
            end else begin
                wgrant = wreq;
                rgrant = rreq;
            end
`else
            wgrant = wreq;
            rgrant = rreq && !wreq;
`endif
        end
    end

    // BRAM port and stream outputs driven from the grant and FIFO head
    always_comb begin
        s_ready    = wgrant;
        bram_ena   = wgrant | rgrant;
        bram_wea   = wgrant;
        bram_addra = wgrant ? wr_ptr : (rgrant ? rd_ptr : '0);
        bram_dina  = wgrant ? s_data : '0;
        push       = inflight;
        pop        = (fifo_count != 2'd0) && m_ready;
        m_valid    = (fifo_count != 2'd0);
        m_data     = fifo_data[fifo_rd_idx];
        m_sof      = fifo_sof[fifo_rd_idx];
        level      = level_q;
    end

    // Pointers, level, in-flight read tracking and the 2-entry output FIFO
    always_ff @(posedge clka) begin
        if (clear) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level_q      <= '0;
            inflight     <= 1'b0;
            inflight_sof <= 1'b0;
            fifo_rd_idx  <= 1'b0;
            fifo_wr_idx  <= 1'b0;
            fifo_count   <= 2'd0;
            fifo_sof     <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
            end
        end else begin
            if (wgrant) begin
                wr_ptr  <= (wr_ptr == LAST) ? '0 : wr_ptr + ADDR_W'(1);
                level_q <= level_q + ADDR_W'(1);
            end else if (rgrant) begin
                level_q <= level_q - ADDR_W'(1);
            end
            if (rgrant) begin
                rd_ptr       <= (rd_ptr == LAST) ? '0 : rd_ptr + ADDR_W'(1);
                inflight_sof <= (rd_ptr == '0);
            end
            inflight <= rgrant;
            if (push) begin
                fifo_data[fifo_wr_idx] <= bram_douta;
                fifo_sof[fifo_wr_idx]  <= inflight_sof;
                fifo_wr_idx            <= ~fifo_wr_idx;
            end
            if (pop) begin
                fifo_rd_idx <= ~fifo_rd_idx;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Sticky misplaced start-of-frame flag; survives flush, cleared by reset only
    always_ff @(posedge clka) begin
        if (rsta) begin
            sof_err <= 1'b0;
        end else if (wgrant && s_sof && (wr_ptr != '0)) begin
            sof_err <= 1'b1;
        end
    end

`ifdef INBUF_ARB_RR_EN
    // Remember the winner of each contested cycle; after clear the writer wins first
    always_ff @(posedge clka) begin
        if (clear) begin
            rr_last <= 1'b0;
        end else if (wreq && rreq) begin
            rr_last <= wgrant;
        end
    end
`endif

endmodule
